// File: rtl/rr_mux4_pkg.sv
// Shared constants for the four-source round-robin mux arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package rr_mux4_pkg;

  localparam int NUM_SRC = 4;

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  function automatic logic [NUM_SRC-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_pick.sv
// Round-robin pick: first set req bit scanning ptr+1, ptr+2, ptr+3, ptr.
// Latency: combinational.
// Backpressure: none.
module rr_pick4
  import rr_mux4_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         ptr,
  output logic               any,
  output logic [1:0]         idx
);

  // Scan from lowest to highest priority so the nearest candidate wins last.
  always_comb begin
    logic [1:0] cand;
    cand = '0;
    any  = 1'b0;
    idx  = ptr;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux; grants bursts of up to MAX_BURST beats.
// Latency: grant one cycle after req; data path y is combinational on the registered select.
// Backpressure: out_ready low holds owner, select and beat count; only accepted beats count.
module rr_mux4_arbiter
  import rr_mux4_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  input  logic               out_ready,
  output logic [NUM_SRC-1:0] gnt,
  output logic               s0,
  output logic               s1,
  output logic [WIDTH-1:0]   y,
  output logic               out_valid,
  output logic               busy
);

  localparam int              CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  logic             state;
  logic [1:0]       sel;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic       owner_req;
  logic       accept;
  logic       grant_done;
  logic [1:0] pick_ptr;
  logic       pick_any;
  logic [1:0] pick_idx;

  assign owner_req  = req[sel];
  assign out_valid  = (state == GRANT) && owner_req;
  assign accept     = out_valid && out_ready;
  assign grant_done = (state == GRANT) && (!owner_req || (accept && (cnt == LAST_BEAT)));

  // On release the pointer becomes the current owner in the same edge, so
  // arbitrate against sel directly instead of waiting for ptr to update.
  assign pick_ptr = (state == GRANT) ? sel : ptr;

  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= SEL_A;
      cnt   <= '0;
      ptr   <= SEL_D;
    end else if (state == IDLE) begin
      if (pick_any) begin
        state <= GRANT;
        gnt   <= onehot4(pick_idx);
        sel   <= pick_idx;
        cnt   <= '0;
      end
    end else begin
      if (grant_done) begin
        ptr <= sel;
        if (pick_any) begin
          gnt <= onehot4(pick_idx);
          sel <= pick_idx;
          cnt <= '0;
        end else begin
          state <= IDLE;
          gnt   <= '0;
        end
      end else if (accept) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    y = a;
    case (sel)
      SEL_A: y = a;
      SEL_B: y = b;
      SEL_C: y = c;
      SEL_D: y = d;
    endcase
  end

  assign s0   = sel[0];
  assign s1   = sel[1];
  assign busy = (state == GRANT);

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 datapath mux among four requesters (a, b, c, d).
- Owns the mux select lines s0/s1 and grants one requester at a time, bursting up to MAX_BURST beats.
- Presents the selected data to a single downstream consumer through a valid/ready handshake.
- Sits between four producer blocks and one shared output channel.

Parameters:
- WIDTH, 8: data width of each input and of y.
- MAX_BURST, 4: maximum accepted beats per grant; legal range is at least 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per source; bit i belongs to source i (0=a, 1=b, 2=c, 3=d).
- a  input  WIDTH  source 0 data.
- b  input  WIDTH  source 1 data.
- c  input  WIDTH  source 2 data.
- d  input  WIDTH  source 3 data.
- out_ready  input  1  downstream accepts a beat this cycle.
- gnt  output  4  registered, one-hot or zero; identifies the current owner.
- s0  output  1  registered mux select, LSB.
- s1  output  1  registered mux select, MSB.
- y  output  WIDTH  mux output: a/b/c/d selected by {s1,s0} = 0/1/2/3.
- out_valid  output  1  beat valid; combinational.
- busy  output  1  high in state GRANT.

Behaviour:
- Reset (takes effect at the rst edge, also mid-burst):
  - state=IDLE, gnt=0000, s1s0=00, beat count=0.
  - Last-grant pointer=3, so source 0 has top priority first.
  - Outputs: out_valid=0, busy=0, y=a.
- Select mapping: sel={s1,s0} = index of the granted source.
  - y is a purely combinational mux of a..d on sel; no data registering.
  - Zero-latency data path: y follows the selected input in the same cycle.
- Pick function: the first asserted req bit scanning pointer+1, pointer+2, pointer+3, pointer (mod 4).
  - The most recent owner therefore has lowest priority.
- IDLE:
  - gnt=0, out_valid=0.
  - If req!=0, at the next edge: state=GRANT, gnt=onehot(pick), sel=pick, count=0.
  - Grant latency is one cycle from req.
- GRANT:
  - out_valid = req[sel].
  - A beat is accepted when out_valid && out_ready; count increments on each accepted beat.
  - count, gnt and sel are held while out_ready=0 (backpressure); count never counts unaccepted cycles.
- Release occurs at an edge in GRANT when either:
  - req[sel]=0 (owner withdrew; no beat counted), or
  - a beat is accepted with count==MAX_BURST-1.
- On release:
  - pointer=sel.
  - If any req is set, including the releasing source, re-arbitrate at the same edge using the updated pointer: gnt/sel go straight to the new winner, count=0, state stays GRANT. There is no idle bubble.
  - If no req is set: state=IDLE, gnt=0000, s1s0 hold their last value.
- A single requester holding req continuously is re-granted back-to-back: count wraps to 0 and gnt is unchanged.
- MAX_BURST=1: release after every accepted beat, giving strict per-beat round-robin.
- Counter: width $clog2(MAX_BURST)+1. count never exceeds MAX_BURST-1.
- Requesters must hold data stable while req=1 and the beat is not yet accepted.
- req changes on non-granted bits during GRANT affect only the next arbitration.
- Invariants: gnt is one-hot in GRANT and zero in IDLE; gnt==onehot(sel) whenever busy=1.

Decomposition:
- Shared package rr_mux4_pkg:
  - State localparams IDLE=1'b0, GRANT=1'b1.
  - Select encodings SEL_A=2'd0, SEL_B=2'd1, SEL_C=2'd2, SEL_D=2'd3.
  - NUM_SRC=4.
- One sub-module rr_pick4: purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
  - Shared by the IDLE and release paths.
- The 4:1 data mux stays inline as a case on sel.

Test Plan:
- Reset, then req=0001, out_ready=1, a=8'hA5:
  - Edge+1: gnt=0001, s1s0=00, y=A5, out_valid=1.
  - After 4 accepted beats, re-granted with no gap; gnt stays 0001.
- req=1111 held, out_ready=1, MAX_BURST=4:
  - Owner sequence 0,1,2,3,0; gnt changes every 4 cycles.
  - s1s0 steps 00,01,10,11,00; y tracks a,b,c,d.
- Backpressure: req=0100 granted, out_ready=0 for 3 cycles then 1:
  - gnt=0100, y=c, out_valid=1 throughout.
  - count holds at 0 while stalled.
  - Release occurs after 4 accepted beats, not 7 cycles.
- Early withdraw: source 0 granted with req=0101; drop req[0] after 2 beats:
  - Next edge: gnt=0100, s1s0=10, count=0, no IDLE cycle.
- Last requester leaves: req drops to 0000 in GRANT:
  - Next edge: IDLE, gnt=0000, out_valid=0, busy=0.
- Reset mid-burst (source 2 owner, count=2), then req=1010:
  - After reset: gnt=0000, s1s0=00.
  - Next grant goes to source 1 first, since pointer=3.
